// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that merges ALU and load writebacks into a one-entry stage
// driving the regfile write port, plus read-after-write hazard flags for decode.
//
// state    | meaning
// ST_EMPTY | no write pending in the output stage
// ST_FULL  | stage holds a write; drains on any edge without wb_hold
module regfile_wb_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_rc,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_rc,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  input  logic          wb_hold,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic          wb_werf,
  output logic [AW-1:0] wb_rc,
  output logic [DW-1:0] wb_wdata,
  output logic          hazard_a,
  output logic          hazard_b,
  output logic          last_grant
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stg_state_t;

  stg_state_t    state, state_nxt;
  logic [AW-1:0] stg_rc;
  logic [DW-1:0] stg_wdata;
  logic          grant_ptr;
  logic          stg_valid;
  logic          drain;
  logic          can_acc;
  logic          gnt_idx;
  logic          accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    stg_valid = (state == ST_FULL);
    drain     = stg_valid && !wb_hold;
    can_acc   = !stg_valid || !wb_hold;
    gnt_idx   = (req0_valid && req1_valid) ? !grant_ptr : req1_valid;
    accept    = can_acc && (req0_valid || req1_valid);
    state_nxt = state;
    if (accept) begin
      state_nxt = ST_FULL;
    end else if (drain) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_rc    <= '0;
      stg_wdata <= '0;
      grant_ptr <= 1'b1;
    end else if (accept) begin
      stg_rc    <= gnt_idx ? req1_rc    : req0_rc;
      stg_wdata <= gnt_idx ? req1_wdata : req0_wdata;
      grant_ptr <= gnt_idx;
    end
  end

  assign req0_ready = accept && !gnt_idx;
  assign req1_ready = accept && gnt_idx;

  // Zero-register writes occupy the stage but never reach the regfile.
  assign wb_werf    = drain && (stg_rc != ZR);
  assign wb_rc      = stg_rc;
  assign wb_wdata   = stg_wdata;
  assign hazard_a   = stg_valid && (stg_rc == ra) && (ra != ZR);
  assign hazard_b   = stg_valid && (stg_rc == rb) && (rb != ZR);
  assign last_grant = grant_ptr;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all outputs compared each cycle against a queue-based model.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_rc, req1_rc, ra, rb, wb_rc;
  logic [31:0] req0_wdata, req1_wdata, wb_wdata;
  logic        wb_hold, wb_werf, hazard_a, hazard_b, last_grant;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.DW(32), .AW(5), .ZERO_REG(31)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_rc(req0_rc), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rc(req1_rc), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .wb_hold(wb_hold), .ra(ra), .rb(rb),
    .wb_werf(wb_werf), .wb_rc(wb_rc), .wb_wdata(wb_wdata),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .last_grant(last_grant)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is a queue of at most one pending write.
  typedef struct packed {
    logic [4:0]  rc;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_last = 1'b1;
  logic [4:0]  m_rc   = '0;
  logic [31:0] m_d    = '0;
  logic [31:0] rf[32];
  bit          written[32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]      = '0;
      written[i] = 1'b0;
    end
  end

  always @(negedge clock) begin
    bit   full, can, any, pick;
    logic e_werf, e_ha, e_hb;
    if (!reset_n) begin
      mq.delete();
      m_last = 1'b1;
      m_rc   = '0;
      m_d    = '0;
    end
    full = (mq.size() != 0);
    can  = !full || !wb_hold;
    any  = req0_valid || req1_valid;
    if (req0_valid && req1_valid) pick = !m_last;
    else                          pick = req1_valid;
    e_werf = full && !wb_hold && (mq[0].rc != 5'd31);
    e_ha   = full && (mq[0].rc == ra) && (ra != 5'd31);
    e_hb   = full && (mq[0].rc == rb) && (rb != 5'd31);
    chk1("m_req0_ready", req0_ready, can && any && !pick);
    chk1("m_req1_ready", req1_ready, can && any && pick);
    chk1("m_wb_werf", wb_werf, e_werf);
    chk32("m_wb_rc", 32'(wb_rc), 32'(m_rc));
    chk32("m_wb_wdata", wb_wdata, m_d);
    chk1("m_hazard_a", hazard_a, e_ha);
    chk1("m_hazard_b", hazard_b, e_hb);
    chk1("m_last_grant", last_grant, m_last);
    if (wb_werf) begin
      rf[wb_rc]      = wb_wdata;
      written[wb_rc] = 1'b1;
    end
    if (reset_n) begin
      if (full && !wb_hold) void'(mq.pop_front());
      if (can && any) begin
        m_rc   = pick ? req1_rc : req0_rc;
        m_d    = pick ? req1_wdata : req0_wdata;
        m_last = pick;
        mq.push_back('{rc: m_rc, d: m_d});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic a0, a1;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_rc = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_rc = '0; req1_wdata = '0;
    wb_hold = 1'b0; ra = '0; rb = '0;

    // Reset and idle
    repeat (2) @(negedge clock);
    chk1("rst_werf", wb_werf, 1'b0);
    chk32("rst_rc", 32'(wb_rc), 32'd0);
    chk32("rst_wdata", wb_wdata, 32'd0);
    chk1("rst_haz_a", hazard_a, 1'b0);
    chk1("rst_haz_b", hazard_b, 1'b0);
    chk1("rst_last_grant", last_grant, 1'b1);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk1("idle_werf", wb_werf, 1'b0);
      chk1("idle_last_grant", last_grant, 1'b1);
    end

    // Single write R1 <= 2
    tick();
    req0_valid = 1'b1; req0_rc = 5'd1; req0_wdata = 32'h2;
    @(negedge clock);
    chk1("single_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    @(negedge clock);
    chk1("single_werf", wb_werf, 1'b1);
    chk32("single_rc", 32'(wb_rc), 32'd1);
    chk32("single_wdata", wb_wdata, 32'h2);
    tick();
    @(negedge clock);
    chk32("single_rf_r1", rf[1], 32'h2);
    chk1("single_last_grant", last_grant, 1'b0);

    // Zero register write from requester 1
    tick();
    req1_valid = 1'b1; req1_rc = 5'd31; req1_wdata = 32'hFFFF_FFFF; rb = 5'd31;
    @(negedge clock);
    chk1("zero_ready", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    @(negedge clock);
    chk1("zero_werf", wb_werf, 1'b0);
    chk1("zero_haz_b", hazard_b, 1'b0);
    chk32("zero_rc", 32'(wb_rc), 32'd31);
    chk1("zero_last_grant", last_grant, 1'b1);

    // Contention: grants alternate 0,1,0,1
    tick();
    rb = '0;
    req0_valid = 1'b1; req0_rc = 5'd5; req0_wdata = 32'd3;
    req1_valid = 1'b1; req1_rc = 5'd6; req1_wdata = 32'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i > 0) begin
        chk32("cont_rc", 32'(wb_rc), (i % 2 == 1) ? 32'd5 : 32'd6);
        chk1("cont_werf", wb_werf, 1'b1);
      end
      chk1("cont_ready0", req0_ready, (i % 2) == 0);
      chk1("cont_ready1", req1_ready, (i % 2) == 1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    chk32("cont_rc_last", 32'(wb_rc), 32'd6);

    // Hold with R5 pending and a queued request from requester 1
    tick();
    req0_valid = 1'b1; req0_rc = 5'd5; req0_wdata = 32'd3;
    @(negedge clock);
    chk1("hold_load_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0; wb_hold = 1'b1; ra = 5'd5;
    req1_valid = 1'b1; req1_rc = 5'd9; req1_wdata = 32'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk1("hold_werf", wb_werf, 1'b0);
      chk1("hold_ready0", req0_ready, 1'b0);
      chk1("hold_ready1", req1_ready, 1'b0);
      chk1("hold_haz_a", hazard_a, 1'b1);
      tick();
    end
    wb_hold = 1'b0;
    @(negedge clock);
    chk1("release_werf", wb_werf, 1'b1);
    chk32("release_rc", 32'(wb_rc), 32'd5);
    chk1("release_ready1", req1_ready, 1'b1);
    chk1("release_haz_a", hazard_a, 1'b1);
    tick();
    req1_valid = 1'b0;
    @(negedge clock);
    chk32("after_rc", 32'(wb_rc), 32'd9);
    chk1("after_werf", wb_werf, 1'b1);
    chk1("after_haz_a", hazard_a, 1'b0);
    chk32("after_rf_r5", rf[5], 32'd3);

    // Reset with R7 pending in the stage
    tick();
    wb_hold = 1'b1;
    req0_valid = 1'b1; req0_rc = 5'd7; req0_wdata = 32'h77;
    @(negedge clock);
    chk1("midrst_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0; reset_n = 1'b0;
    @(negedge clock);
    chk1("midrst_werf", wb_werf, 1'b0);
    chk32("midrst_rc", 32'(wb_rc), 32'd0);
    tick();
    reset_n = 1'b1; wb_hold = 1'b0;
    @(negedge clock);
    chk1("midrst_last_grant", last_grant, 1'b1);
    repeat (3) @(negedge clock);
    chk1("midrst_no_r7", written[7], 1'b0);

    // Randomized traffic; requests stay stable until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      tick();
      if (c == 1500) reset_n = 1'b0;
      if (c == 1502) reset_n = 1'b1;
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_rc    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        req0_wdata = $urandom();
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_rc    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        req1_wdata = $urandom();
      end
      wb_hold = ($urandom_range(0, 9) < 3);
      ra = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    end
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
